// File: rtl/stable_bus_synchronizer_pkg.sv
// ============================================================================
//  Package : domain_crossing_pkg
//  Shared types for the stable bus synchronizer filter.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package domain_crossing_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } stable_sync_state_t;

endpackage

`default_nettype wire

// File: rtl/stable_bus_synchronizer_if.sv
// ============================================================================
//  Interface : stable_bus_synchronizer_if
//  Source bus in, committed bus and status out. The optional changed mask
//  exists only when STABLE_BUS_SYNC_CHANGED_MASK_EN is defined.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface stable_bus_synchronizer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic             update;
   logic             busy;
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
   logic [WIDTH-1:0] changed;

   modport master (output in, input out, input update, input busy, input changed);
   modport slave  (input in, output out, output update, output busy, output changed);
`else
   modport master (output in, input out, input update, input busy);
   modport slave  (input in, output out, output update, output busy);
`endif
endinterface

`default_nettype wire

// File: rtl/stable_bus_synchronizer_sync_chain.sv
// ============================================================================
//  Module : sync_chain
//  Per-bit multi-flop synchronizer, synchronous active-low reset.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_chain #(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [WIDTH-1:0] i_data,
   output logic      [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stage [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_stage[i] <= RESET_VALUE;
         end
      end else begin
         r_stage[0] <= i_data;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_data = r_stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/stable_bus_synchronizer.sv
// ============================================================================
//  Module : stable_bus_synchronizer
//  Synchronizes an async bus and commits a value only after it has been
//  stable for STABLE_CYCLES samples. Optional: STABLE_BUS_SYNC_CHANGED_MASK_EN.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module stable_bus_synchronizer
   import domain_crossing_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter int               SYNC_STAGES   = 2,
   parameter int               STABLE_CYCLES = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input wire logic                 clk,
   input wire logic                 rst,
   stable_bus_synchronizer_if.slave bus
);

   localparam int                 c_cnt_w    = $clog2(STABLE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0]   w_synced;
   logic [WIDTH-1:0]   r_out;
   logic [WIDTH-1:0]   r_cand;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_update;
   stable_sync_state_t r_state;
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
   logic [WIDTH-1:0]   r_changed;
`endif

   sync_chain #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VALUE (RESET_VALUE)
   ) u_sync_chain (
      .clk    (clk),
      .rst    (rst),
      .i_data (bus.in),
      .o_data (w_synced)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out     <= RESET_VALUE;
         r_cand    <= RESET_VALUE;
         r_cnt     <= '0;
         r_update  <= 1'b0;
         r_state   <= IDLE;
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
         r_changed <= '0;
`endif
      end else begin
         r_update  <= 1'b0;
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
         r_changed <= '0;
`endif
         case (r_state)
            IDLE: begin
               if (w_synced != r_out) begin
                  // A single stable sample is enough: commit straight away.
                  if (STABLE_CYCLES == 1) begin
                     r_out     <= w_synced;
                     r_update  <= 1'b1;
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
                     r_changed <= r_out ^ w_synced;
`endif
                  end else begin
                     r_cand  <= w_synced;
                     r_cnt   <= c_cnt_w'(1);
                     r_state <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (w_synced == r_out) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else if (w_synced != r_cand) begin
                  r_cand <= w_synced;
                  r_cnt  <= c_cnt_w'(1);
               end else if (r_cnt == c_cnt_last) begin
                  r_out     <= r_cand;
                  r_update  <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= IDLE;
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
                  r_changed <= r_out ^ r_cand;
`endif
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.out    = r_out;
   assign bus.update = r_update;
   assign bus.busy   = (r_state == SETTLE);
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
   assign bus.changed = r_changed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stable_bus_synchronizer.sv
// ============================================================================
//  Module : tb_stable_bus_synchronizer
//  Directed bench for two configurations with a sliding-window reference model.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stable_bus_synchronizer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   a_pulses    = 0;

   always #5 clk = ~clk;

   stable_bus_synchronizer_if #(.WIDTH(8)) a_bus ();
   stable_bus_synchronizer_if #(.WIDTH(8)) b_bus ();

   stable_bus_synchronizer #(
      .WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(3), .RESET_VALUE(8'hA5)
   ) dut_a (.clk(clk), .rst(rst), .bus(a_bus));

   stable_bus_synchronizer #(
      .WIDTH(8), .SYNC_STAGES(3), .STABLE_CYCLES(1), .RESET_VALUE(8'h00)
   ) dut_b (.clk(clk), .rst(rst), .bus(b_bus));

   // Model: synced = input delayed by ns samples; commit when the last nst
   // synced samples are all equal and differ from the committed value.
   int         ns_of  [2] = '{2, 3};
   int         nst_of [2] = '{3, 1};
   logic [7:0] rv_of  [2] = '{8'hA5, 8'h00};
   logic [7:0] pipe   [2][4];
   logic [7:0] win    [2][4];
   logic [7:0] m_out  [2];
   logic [7:0] m_chg  [2];
   logic       m_upd  [2];
   logic       m_busy [2];
   bit         m_valid = 1'b0;

   task automatic mstep(input int i, input logic rstn, input logic [7:0] din);
      logic [7:0] s;
      bit         all_eq;
      bit         commit;
      if (!rstn) begin
         for (int k = 0; k < 4; k++) begin
            pipe[i][k] = rv_of[i];
            win[i][k]  = rv_of[i];
         end
         m_out[i]  = rv_of[i];
         m_upd[i]  = 1'b0;
         m_busy[i] = 1'b0;
         m_chg[i]  = 8'h00;
      end else begin
         s = pipe[i][ns_of[i]-1];
         for (int k = nst_of[i] - 1; k > 0; k--) win[i][k] = win[i][k-1];
         win[i][0] = s;
         all_eq = 1'b1;
         for (int k = 0; k < nst_of[i]; k++) if (win[i][k] != s) all_eq = 1'b0;
         commit    = all_eq && (s != m_out[i]);
         m_upd[i]  = commit;
         m_busy[i] = (s != m_out[i]) && !commit;
         m_chg[i]  = commit ? (m_out[i] ^ s) : 8'h00;
         if (commit) m_out[i] = s;
         for (int k = ns_of[i] - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
         pipe[i][0] = din;
      end
   endtask

   always @(posedge clk) begin
      mstep(0, rst, a_bus.in);
      mstep(1, rst, b_bus.in);
      if (!rst) m_valid = 1'b1;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model a.out",    a_bus.out,            m_out[0]);
         chk("model a.update", {7'b0, a_bus.update}, {7'b0, m_upd[0]});
         chk("model a.busy",   {7'b0, a_bus.busy},   {7'b0, m_busy[0]});
         chk("model b.out",    b_bus.out,            m_out[1]);
         chk("model b.update", {7'b0, b_bus.update}, {7'b0, m_upd[1]});
         chk("model b.busy",   {7'b0, b_bus.busy},   {7'b0, m_busy[1]});
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
         chk("model a.changed", a_bus.changed, m_chg[0]);
         chk("model b.changed", b_bus.changed, m_chg[1]);
`endif
         if (a_bus.update === 1'b1) a_pulses++;
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int pulses_before;
      a_bus.in = 8'h00;
      b_bus.in = 8'h00;
      rst      = 1'b0;
      run(2);
      chk("reset a.out",    a_bus.out,            8'hA5);
      chk("reset a.update", {7'b0, a_bus.update}, 8'h00);
      chk("reset a.busy",   {7'b0, a_bus.busy},   8'h00);
      chk("reset b.out",    b_bus.out,            8'h00);
      rst = 1'b1;
      run(4);
      chk("post-reset edge4 a.out", a_bus.out, 8'hA5);
      run(1);
      chk("post-reset edge5 a.out",    a_bus.out,            8'h00);
      chk("post-reset edge5 a.update", {7'b0, a_bus.update}, 8'h01);

      // 00 -> 3C held
      a_bus.in = 8'h3C;
      run(2);
      chk("3C edge2 busy", {7'b0, a_bus.busy}, 8'h00);
      run(1);
      chk("3C edge3 busy", {7'b0, a_bus.busy}, 8'h01);
      run(1);
      chk("3C edge4 busy", {7'b0, a_bus.busy}, 8'h01);
      run(1);
      chk("3C edge5 out",    a_bus.out,            8'h3C);
      chk("3C edge5 update", {7'b0, a_bus.update}, 8'h01);
      chk("3C edge5 busy",   {7'b0, a_bus.busy},   8'h00);
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
      chk("3C edge5 changed", a_bus.changed, 8'h3C);
`endif
      run(1);
      chk("3C edge6 update", {7'b0, a_bus.update}, 8'h00);
`ifdef STABLE_BUS_SYNC_CHANGED_MASK_EN
      chk("3C edge6 changed", a_bus.changed, 8'h00);
`endif

      // short FF glitch over 00
      a_bus.in = 8'h00;
      run(6);
      chk("back to 00 out", a_bus.out, 8'h00);
      pulses_before = a_pulses;
      a_bus.in = 8'hFF;
      run(2);
      a_bus.in = 8'h00;
      run(8);
      chk("glitch out",    a_bus.out,          8'h00);
      chk("glitch busy",   {7'b0, a_bus.busy}, 8'h00);
      chk("glitch pulses", 8'(a_pulses - pulses_before), 8'h00);

      // 11 then 22 one cycle later
      a_bus.in = 8'h11;
      run(1);
      a_bus.in = 8'h22;
      run(4);
      chk("restart edge5 update", {7'b0, a_bus.update}, 8'h00);
      chk("restart edge5 out",    a_bus.out,            8'h00);
      run(1);
      chk("restart edge6 out",    a_bus.out,            8'h22);
      chk("restart edge6 update", {7'b0, a_bus.update}, 8'h01);

      // STABLE_CYCLES=1, SYNC_STAGES=3 instance
      b_bus.in = 8'h01;
      run(3);
      chk("b 01 edge3 update", {7'b0, b_bus.update}, 8'h00);
      run(1);
      chk("b 01 edge4 out",    b_bus.out,            8'h01);
      chk("b 01 edge4 update", {7'b0, b_bus.update}, 8'h01);
      b_bus.in = 8'h02;
      run(3);
      chk("b 02 edge3 out",    b_bus.out,            8'h01);
      run(1);
      chk("b 02 edge4 out",    b_bus.out,            8'h02);
      chk("b 02 edge4 update", {7'b0, b_bus.update}, 8'h01);

      // reset while settling
      a_bus.in = 8'h3C;
      run(3);
      chk("pre-reset busy", {7'b0, a_bus.busy}, 8'h01);
      rst = 1'b0;
      run(1);
      chk("mid-settle reset out",    a_bus.out,            8'hA5);
      chk("mid-settle reset busy",   {7'b0, a_bus.busy},   8'h00);
      chk("mid-settle reset update", {7'b0, a_bus.update}, 8'h00);
      rst = 1'b1;
      run(8);
      chk("after reset recommit out", a_bus.out, 8'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
